// File: rtl/sram_wb_pkg.sv
// Shared types and sizes for the Wishbone window onto the 32x256 result SRAM.
// SRAM_WB_WRITE_EN adds the WR_ISSUE state used by the SoC write path.
package sram_wb_pkg;

  localparam int SRAM_AW = 8;
  localparam int SRAM_DW = 32;
  localparam int WIN_W   = 10;

`ifdef SRAM_WB_WRITE_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_WR_ISSUE = 3'd4,
    ST_ACK      = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_ACK      = 3'd5
  } state_t;
`endif

endpackage

// File: rtl/sram_wb_addr_dec.sv
// Combinational window match and word-index extraction for the SRAM window.
// Byte lane bits adr[1:0] are deliberately ignored.
module sram_wb_addr_dec
  import sram_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic               i_cyc,
  input  logic               i_stb,
  input  logic [31:0]        i_adr,
  output logic               o_hit,
  output logic [SRAM_AW-1:0] o_idx
);

  logic w_unused_adr;

  assign o_hit        = i_cyc & i_stb & (i_adr[31:WIN_W] == BASE_ADDR[31:WIN_W]);
  assign o_idx        = i_adr[WIN_W-1:2];
  assign w_unused_adr = ^i_adr[1:0];

endmodule

// File: rtl/sram_wb_reader.sv
// Wishbone responder giving the SoC word access to the spectrometer result SRAM.
// Define SRAM_WB_WRITE_EN to let full-word SoC writes reach the W0 port.
module sram_wb_reader
  import sram_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] LOCK_PATTERN = 32'hDEAD_BEEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               sram_lock_i,
  output logic               R0_clk,
  output logic               R0_en,
  output logic [SRAM_AW-1:0] R0_addr,
  input  logic [SRAM_DW-1:0] R0_data,
  output logic               W0_clk,
  output logic               W0_en,
  output logic [SRAM_AW-1:0] W0_addr,
  output logic [SRAM_DW-1:0] W0_data,
  output logic [2:0]         o_dbg_state
);

  state_t               r_state;
  logic                 r_ack;
  logic                 r_is_rd;
  logic [SRAM_DW-1:0]   r_dat;
  logic                 r_r0_en;
  logic [SRAM_AW-1:0]   r_r0_addr;
  logic                 w_hit;
  logic [SRAM_AW-1:0]   w_idx;

  sram_wb_addr_dec #(.BASE_ADDR(BASE_ADDR)) u_addr_dec (
    .i_cyc (wbs_cyc_i),
    .i_stb (wbs_stb_i),
    .i_adr (wbs_adr_i),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

`ifdef SRAM_WB_WRITE_EN
  logic                 r_w0_en;
  logic [SRAM_AW-1:0]   r_w0_addr;
  logic [SRAM_DW-1:0]   r_w0_data;

  assign W0_en   = r_w0_en;
  assign W0_addr = r_w0_addr;
  assign W0_data = r_w0_data;
`else
  logic w_unused_wr;

  assign W0_en       = 1'b0;
  assign W0_addr     = '0;
  assign W0_data     = '0;
  assign w_unused_wr = ^{wbs_dat_i, wbs_sel_i};
`endif

  // Strobes are single-cycle pulses: cleared by default, set only on entry to an ISSUE/ACK state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_is_rd   <= 1'b0;
      r_dat     <= '0;
      r_r0_en   <= 1'b0;
      r_r0_addr <= '0;
`ifdef SRAM_WB_WRITE_EN
      r_w0_en   <= 1'b0;
      r_w0_addr <= '0;
      r_w0_data <= '0;
`endif
    end else begin
      r_ack   <= 1'b0;
      r_r0_en <= 1'b0;
`ifdef SRAM_WB_WRITE_EN
      r_w0_en <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_is_rd <= ~wbs_we_i;
            if (sram_lock_i) begin
              r_state <= ST_LOCKED;
            end else if (!wbs_we_i) begin
              r_state   <= ST_RD_ISSUE;
              r_r0_en   <= 1'b1;
              r_r0_addr <= w_idx;
`ifdef SRAM_WB_WRITE_EN
            end else if (wbs_sel_i == 4'hF) begin
              r_state   <= ST_WR_ISSUE;
              r_w0_en   <= 1'b1;
              r_w0_addr <= w_idx;
              r_w0_data <= wbs_dat_i;
`endif
            end else begin
              // Partial writes cannot be masked by the macro, so they take the drop path.
              r_state <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (r_is_rd) r_dat <= LOCK_PATTERN;
          r_ack   <= 1'b1;
          r_state <= ST_ACK;
        end
        ST_RD_ISSUE: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_dat   <= R0_data;
          r_ack   <= 1'b1;
          r_state <= ST_ACK;
        end
`ifdef SRAM_WB_WRITE_EN
        ST_WR_ISSUE: begin
          r_ack   <= 1'b1;
          r_state <= ST_ACK;
        end
`endif
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign R0_clk      = wb_clk_i;
  assign W0_clk      = wb_clk_i;
  assign R0_en       = r_r0_en;
  assign R0_addr     = r_r0_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_wb_reader.sv
// Self-checking bench for sram_wb_reader with a behavioural synchronous SRAM model.
// Honours SRAM_WB_WRITE_EN in the same way as the design.
module tb_sram_wb_reader;
  import sram_wb_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] LPAT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        lock = 1'b0;
  logic        ack;
  logic [31:0] rdat_o;
  logic        r0_clk, r0_en, w0_clk, w0_en;
  logic [7:0]  r0_addr, w0_addr;
  logic [31:0] r0_data, w0_data;
  logic [2:0]  dbg_state;

  logic [31:0] mem [256];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  sram_wb_reader #(.BASE_ADDR(BASE), .LOCK_PATTERN(LPAT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat_o),
    .sram_lock_i (lock),
    .R0_clk      (r0_clk),
    .R0_en       (r0_en),
    .R0_addr     (r0_addr),
    .R0_data     (r0_data),
    .W0_clk      (w0_clk),
    .W0_en       (w0_en),
    .W0_addr     (w0_addr),
    .W0_data     (w0_data),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous SRAM model: data appears the cycle after the enable
  always @(posedge clk) begin
    if (r0_en) r0_data <= mem[r0_addr];
    if (w0_en) mem[w0_addr] <= w0_data;
  end

  // driver: stb goes high in cycle 0, then observe cycles 1..12 at the negedge
  task automatic access(input logic i_we, input logic [31:0] i_adr, input logic [31:0] i_dat,
                        input logic [3:0] i_sel, output int ack_cyc, output int r0_cyc,
                        output int w0_cyc, output logic [7:0] en_addr, output logic [31:0] got,
                        output int en_cnt, output int both_cnt);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = i_we; adr = i_adr; wdat = i_dat; sel = i_sel;
    ack_cyc = -1; r0_cyc = -1; w0_cyc = -1; en_addr = '0; got = '0; en_cnt = 0; both_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (r0_en && w0_en) both_cnt++;
      if (r0_en) begin en_cnt++; r0_cyc = c; en_addr = r0_addr; end
      if (w0_en) begin en_cnt++; w0_cyc = c; en_addr = w0_addr; end
      if (ack) begin
        ack_cyc = c; got = rdat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  int          a_c, r_c, w_c, e_n, b_n;
  logic [7:0]  e_a;
  logic [31:0] g_d, e_d, old_v;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_vec++; if ({r0_en, w0_en} !== 2'b00) begin n_err++; $display("FAIL reset_en: got %b want 00", {r0_en, w0_en}); end
    n_vec++; if ({r0_addr, w0_addr} !== 16'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0000", {r0_addr, w0_addr}); end
    n_vec++; if (w0_data !== 32'h0) begin n_err++; $display("FAIL reset_w0_data: got %h want 0", w0_data); end
    n_vec++; if (rdat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat_o: got %h want 0", rdat_o); end
    n_vec++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    mem[5] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    access(1'b0, 32'h3000_0014, 32'h0, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (r_c !== 1) begin n_err++; $display("FAIL rd_r0_en_cycle: got %0d want 1", r_c); end
    n_vec++; if (e_a !== 8'd5) begin n_err++; $display("FAIL rd_addr: got %0d want 5", e_a); end
    n_vec++; if (e_n !== 1) begin n_err++; $display("FAIL rd_en_count: got %0d want 1", e_n); end
    n_vec++; if (a_c !== 3) begin n_err++; $display("FAIL rd_ack_cycle: got %0d want 3", a_c); end
    if (a_c >= 0) begin
      e_d = exp_q.pop_front();
      n_vec++; if (g_d !== e_d) begin n_err++; $display("FAIL rd_data: got %h want %h", g_d, e_d); end
    end
    @(negedge clk);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rd_ack_width: got %b want 0", ack); end
    n_vec++; if (rdat_o !== 32'h1234_5678) begin n_err++; $display("FAIL rd_data_hold: got %h want 12345678", rdat_o); end
  endtask

  task automatic test_random_reads();
    int idx;
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(0, 255);
      v = $urandom;
      mem[idx] = v;
      exp_q.push_back(v);
      access(1'b0, BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), 32'h0, 4'hF,
             a_c, r_c, w_c, e_a, g_d, e_n, b_n);
      n_vec++; if (a_c !== 3 || e_a !== 8'(idx)) begin
        n_err++; $display("FAIL rnd_rd_timing: ack %0d addr %0d want 3 %0d", a_c, e_a, idx);
      end
      if (a_c >= 0) begin
        e_d = exp_q.pop_front();
        n_vec++; if (g_d !== e_d) begin n_err++; $display("FAIL rnd_rd_data: got %h want %h", g_d, e_d); end
      end
    end
  endtask

  task automatic test_write();
    old_v = mem[255];
    access(1'b1, 32'h3000_03FC, 32'hA5A5_0001, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== 2) begin n_err++; $display("FAIL wr_ack_cycle: got %0d want 2", a_c); end
    n_vec++; if (b_n !== 0) begin n_err++; $display("FAIL wr_both_en: got %0d want 0", b_n); end
`ifdef SRAM_WB_WRITE_EN
    n_vec++; if (w_c !== 1 || e_a !== 8'd255 || e_n !== 1) begin
      n_err++; $display("FAIL wr_w0: cycle %0d addr %0d cnt %0d want 1 255 1", w_c, e_a, e_n);
    end
    exp_q.push_back(32'hA5A5_0001);
`else
    n_vec++; if (e_n !== 0) begin n_err++; $display("FAIL wr_no_en: got %0d want 0", e_n); end
    exp_q.push_back(old_v);
`endif
    access(1'b0, 32'h3000_03FC, 32'h0, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== 3) begin n_err++; $display("FAIL wr_rb_ack: got %0d want 3", a_c); end
    if (a_c >= 0) begin
      e_d = exp_q.pop_front();
      n_vec++; if (g_d !== e_d) begin n_err++; $display("FAIL wr_readback: got %h want %h", g_d, e_d); end
    end
  endtask

  task automatic test_lock();
    lock = 1'b1;
    exp_q.push_back(LPAT);
    access(1'b0, 32'h3000_0000, 32'h0, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== 2 || e_n !== 0) begin
      n_err++; $display("FAIL lock_rd: ack %0d en %0d want 2 0", a_c, e_n);
    end
    if (a_c >= 0) begin
      e_d = exp_q.pop_front();
      n_vec++; if (g_d !== e_d) begin n_err++; $display("FAIL lock_rd_data: got %h want %h", g_d, e_d); end
    end
    old_v = mem[0];
    access(1'b1, 32'h3000_0000, 32'hFFFF_0000, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== 2 || e_n !== 0) begin
      n_err++; $display("FAIL lock_wr: ack %0d en %0d want 2 0", a_c, e_n);
    end
    n_vec++; if (g_d !== LPAT) begin n_err++; $display("FAIL lock_wr_dat_hold: got %h want %h", g_d, LPAT); end
    @(negedge clk);
    n_vec++; if (mem[0] !== old_v) begin n_err++; $display("FAIL lock_wr_mem: got %h want %h", mem[0], old_v); end
    lock = 1'b0;
    // lock raised after the access was accepted must not abort it
    mem[9] = 32'h0BAD_F00D;
    exp_q.push_back(32'h0BAD_F00D);
    fork
      access(1'b0, 32'h3000_0024, 32'h0, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
      begin @(negedge clk); @(negedge clk); lock = 1'b1; end
    join
    lock = 1'b0;
    n_vec++; if (a_c !== 3 || r_c !== 1) begin
      n_err++; $display("FAIL midlock_rd: ack %0d r0 %0d want 3 1", a_c, r_c);
    end
    if (a_c >= 0) begin
      e_d = exp_q.pop_front();
      n_vec++; if (g_d !== e_d) begin n_err++; $display("FAIL midlock_data: got %h want %h", g_d, e_d); end
    end
  endtask

  task automatic test_miss();
    access(1'b0, 32'h3000_0400, 32'h0, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== -1 || e_n !== 0) begin
      n_err++; $display("FAIL miss_rd: ack %0d en %0d want -1 0", a_c, e_n);
    end
    access(1'b1, 32'h2FFF_FFFC, 32'h1111_2222, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== -1 || e_n !== 0) begin
      n_err++; $display("FAIL miss_wr: ack %0d en %0d want -1 0", a_c, e_n);
    end
    old_v = mem[5];
    access(1'b1, 32'h3000_0014, 32'h7777_7777, 4'h3, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== 2 || e_n !== 0) begin
      n_err++; $display("FAIL partial_wr: ack %0d en %0d want 2 0", a_c, e_n);
    end
    @(negedge clk);
    n_vec++; if (mem[5] !== old_v) begin n_err++; $display("FAIL partial_wr_mem: got %h want %h", mem[5], old_v); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0014; sel = 4'hF;
    @(negedge clk);
    n_vec++; if (r0_en !== 1'b1) begin n_err++; $display("FAIL rst_mid_issue: got %b want 1", r0_en); end
    @(negedge clk);
    n_vec++; if (dbg_state !== 3'(ST_RD_WAIT)) begin n_err++; $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, 3'(ST_RD_WAIT)); end
    rst = 1'b1;
    #1;
    n_vec++; if ({ack, r0_en, w0_en, r0_addr, rdat_o} !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: ack %b r0 %b w0 %b addr %h dat %h want all 0", ack, r0_en, w0_en, r0_addr, rdat_o);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_ack: got %b want 0", ack); end
    end
    exp_q.push_back(mem[5]);
    access(1'b0, 32'h3000_0014, 32'h0, 4'hF, a_c, r_c, w_c, e_a, g_d, e_n, b_n);
    n_vec++; if (a_c !== 3 || e_a !== 8'd5) begin n_err++; $display("FAIL rst_mid_next: ack %0d addr %0d want 3 5", a_c, e_a); end
    if (a_c >= 0) begin
      e_d = exp_q.pop_front();
      n_vec++; if (g_d !== e_d) begin n_err++; $display("FAIL rst_mid_next_data: got %h want %h", g_d, e_d); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    r0_data = 32'h0;
    test_reset();
    test_read();
    test_random_reads();
    test_write();
    test_lock();
    test_miss();
    test_reset_mid();
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
